// File: rtl/fp64_exp2_pkg.sv
// Shared constants for the sequential 2^a unit: polynomial coefficients,
// binary64 special encodings and FSM state encoding.
package fp64_exp2_pkg;

    localparam logic [63:0] FP64_POS_INF = 64'h7FF0000000000000;
    localparam logic [63:0] FP64_ONE     = 64'h3FF0000000000000;
    localparam logic [10:0] EXP_BIAS     = 11'd1023;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SPECIAL = 3'd1;
    localparam logic [2:0] ST_SPLIT   = 3'd2;
    localparam logic [2:0] ST_MUL     = 3'd3;
    localparam logic [2:0] ST_ADD     = 3'd4;
    localparam logic [2:0] ST_SCALE   = 3'd5;

    function automatic logic [63:0] exp2_coef(input logic [2:0] k);
        logic [63:0] c;
        case (k)
            3'd0:    c = 64'h3FF0000000000000;
            3'd1:    c = 64'h3FE62E42FEFA39EF;
            3'd2:    c = 64'h3FCEBFBDFF82C58E;
            3'd3:    c = 64'h3FAC6B08D704A0BF;
            3'd4:    c = 64'h3F83B2AB6FBA4E77;
            3'd5:    c = 64'h3F55D87FE78A6730;
            3'd6:    c = 64'h3F2430912F86C786;
            default: c = 64'h0000000000000000;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/fp64_add.sv
// Combinational binary64 adder: subnormals flush to zero, result truncated.
module fp64_add (
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic [63:0] y
);
    logic               swap_s;
    logic [63:0]        big_s;
    logic [63:0]        small_s;
    logic [10:0]        dexp_s;
    logic [56:0]        mb_s;
    logic [56:0]        ms_s;
    logic [56:0]        sum_s;
    logic [56:0]        norm_s;
    logic [5:0]         lead_s;
    logic signed [12:0] exp_s;
    logic               unused_s;

    // Larger magnitude goes first so subtraction never goes negative.
    assign swap_s   = a[62:0] < b[62:0];
    assign big_s    = swap_s ? b : a;
    assign small_s  = swap_s ? a : b;
    assign dexp_s   = big_s[62:52] - small_s[62:52];
    assign mb_s     = {2'b01, big_s[51:0], 3'b000};
    assign ms_s     = (dexp_s > 11'd56) ? 57'd0 : ({2'b01, small_s[51:0], 3'b000} >> dexp_s);
    assign sum_s    = (big_s[63] == small_s[63]) ? (mb_s + ms_s) : (mb_s - ms_s);
    assign norm_s   = sum_s << (6'd56 - lead_s);
    assign exp_s    = $signed({2'b00, big_s[62:52]}) + $signed({7'd0, lead_s}) - 13'sd55;
    assign unused_s = ^{norm_s[56], norm_s[3:0]};

    // Leading-one position of the raw sum.
    always_comb begin
        lead_s = 6'd0;
        for (int i = 0; i < 57; i++) begin
            lead_s = sum_s[i] ? 6'(i) : lead_s;
        end
    end

    // Result packing with zero, inf and cancellation cases first.
    always_comb begin
        y = 64'd0;
        if (big_s[62:52] == 11'd0) begin
            y = 64'd0;
        end else if (big_s[62:52] == 11'h7FF || small_s[62:52] == 11'd0) begin
            y = big_s;
        end else if (sum_s == 57'd0) begin
            y = 64'd0;
        end else if (exp_s >= 13'sd2047) begin
            y = {big_s[63], 11'h7FF, 52'd0};
        end else if (exp_s <= 13'sd0) begin
            y = {big_s[63], 63'd0};
        end else begin
            y = {big_s[63], exp_s[10:0], norm_s[55:4]};
        end
    end

endmodule

// File: rtl/fp64_exp2_prep.sv
// Operand classification, truncation of a to signed integer n and the
// binary64 encoding of -n used to form the fractional part.
module fp64_exp2_prep
    import fp64_exp2_pkg::*;
(
    input  logic [63:0]        a,
    output logic               is_zero,
    output logic               is_inf,
    output logic               is_nan,
    output logic signed [12:0] n,
    output logic [63:0]        neg_n_fp
);
    logic [10:0] exp_s;
    logic [63:0] int_s;
    logic [11:0] mag_s;
    logic [3:0]  lead_s;
    logic [63:0] frac_s;

    assign exp_s   = a[62:52];
    assign is_zero = (a[62:0] == 63'd0);
    assign is_inf  = (exp_s == 11'h7FF) && (a[51:0] == 52'd0);
    assign is_nan  = (exp_s == 11'h7FF) && (a[51:0] != 52'd0);

    // |trunc(a)|; values past 2047 clamp so n plus any exponent stays in 13 bits.
    always_comb begin
        int_s = 64'd0;
        mag_s = 12'd0;
        if (exp_s < EXP_BIAS) begin
            mag_s = 12'd0;
        end else if (exp_s >= 11'd1036) begin
            mag_s = 12'd1024;
        end else begin
            int_s = {11'd0, 1'b1, a[51:0]} >> (11'd1075 - exp_s);
            mag_s = (int_s[63:11] != 53'd0) ? 12'd2047 : int_s[11:0];
        end
    end

    // Leading-one position of the integer magnitude for int-to-fp conversion.
    always_comb begin
        lead_s = 4'd0;
        for (int i = 0; i < 12; i++) begin
            lead_s = mag_s[i] ? 4'(i) : lead_s;
        end
    end

    assign frac_s   = {52'd0, mag_s} << (6'd52 - {2'b00, lead_s});
    assign n        = a[63] ? -$signed({1'b0, mag_s}) : $signed({1'b0, mag_s});
    assign neg_n_fp = (mag_s == 12'd0) ? 64'd0
                    : {~a[63], EXP_BIAS + {7'd0, lead_s}, frac_s[51:0]};

endmodule

// File: rtl/fp64_mul.sv
// Combinational binary64 multiplier: subnormals flush to zero, result truncated.
module fp64_mul (
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic [63:0] y
);
    logic               sign_s;
    logic [105:0]       prod_s;
    logic [51:0]        mant_s;
    logic signed [12:0] exp_s;
    logic               unused_s;

    assign sign_s   = a[63] ^ b[63];
    assign prod_s   = {53'd0, 1'b1, a[51:0]} * {53'd0, 1'b1, b[51:0]};
    assign mant_s   = prod_s[105] ? prod_s[104:53] : prod_s[103:52];
    assign exp_s    = $signed({2'b00, a[62:52]}) + $signed({2'b00, b[62:52]})
                    - 13'sd1023 + $signed({12'd0, prod_s[105]});
    assign unused_s = ^prod_s[51:0];

    // Pack result with zero/inf operands and exponent range handled first.
    always_comb begin
        y = 64'd0;
        if (a[62:52] == 11'd0 || b[62:52] == 11'd0) begin
            y = {sign_s, 63'd0};
        end else if (a[62:52] == 11'h7FF || b[62:52] == 11'h7FF) begin
            y = {sign_s, 11'h7FF, 52'd0};
        end else if (exp_s >= 13'sd2047) begin
            y = {sign_s, 11'h7FF, 52'd0};
        end else if (exp_s <= 13'sd0) begin
            y = {sign_s, 63'd0};
        end else begin
            y = {sign_s, exp_s[10:0], mant_s};
        end
    end

endmodule

// File: rtl/fp64_exp2_seq.sv
// Sequential 2^a: a = n + f, Horner evaluation of 2^f on one shared
// multiplier and adder, then n folded into the result exponent.
module fp64_exp2_seq
    import fp64_exp2_pkg::*;
#(
    parameter int ORDER = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [63:0] a,
    output logic        busy,
    output logic        done,
    output logic [63:0] y,
    output logic        overflow,
    output logic        underflow,
    output logic        inexact
);
    logic [2:0]         state_r;
    logic [63:0]        a_r;
    logic signed [12:0] n_r;
    logic [63:0]        neg_n_fp_r;
    logic [63:0]        f_r;
    logic [63:0]        acc_r;
    logic [2:0]         k_r;

    logic               is_zero_s, is_inf_s, is_nan_s;
    logic signed [12:0] n_s;
    logic [63:0]        neg_n_fp_s;
    logic [63:0]        add_a_s, add_b_s, add_y_s, mul_y_s;
    logic [63:0]        special_y_s, scale_y_s;
    logic               scale_ov_s, scale_un_s;
    logic signed [12:0] exp_adj_s;

    fp64_exp2_prep u_prep (
        .a        (a),
        .is_zero  (is_zero_s),
        .is_inf   (is_inf_s),
        .is_nan   (is_nan_s),
        .n        (n_s),
        .neg_n_fp (neg_n_fp_s)
    );

    fp64_mul u_mul (.a(acc_r), .b(f_r), .y(mul_y_s));
    fp64_add u_add (.a(add_a_s), .b(add_b_s), .y(add_y_s));

    // Adder operand mux, selected by state only.
    always_comb begin
        if (state_r == ST_SPLIT) begin
            add_a_s = a_r;
            add_b_s = neg_n_fp_r;
        end else begin
            add_a_s = acc_r;
            add_b_s = exp2_coef(k_r);
        end
    end

    // Results for zero, inf and NaN operands.
    always_comb begin
        if (a_r[62:52] != 11'h7FF) begin
            special_y_s = FP64_ONE;
        end else if (a_r[51:0] != 52'd0) begin
            special_y_s = {1'b0, 11'h7FF, 1'b1, a_r[50:0]};
        end else if (a_r[63]) begin
            special_y_s = 64'd0;
        end else begin
            special_y_s = FP64_POS_INF;
        end
    end

    assign exp_adj_s = $signed({2'b00, acc_r[62:52]}) + n_r;

    // Exponent adjustment by n with saturation and flush.
    always_comb begin
        scale_y_s  = 64'd0;
        scale_ov_s = 1'b0;
        scale_un_s = 1'b0;
        if (acc_r[62:52] == 11'd0) begin
            scale_y_s = acc_r;
        end else if (exp_adj_s >= 13'sd2047) begin
            scale_y_s  = FP64_POS_INF;
            scale_ov_s = 1'b1;
        end else if (exp_adj_s <= 13'sd0) begin
            scale_y_s  = 64'd0;
            scale_un_s = 1'b1;
        end else begin
            scale_y_s = {acc_r[63], exp_adj_s[10:0], acc_r[51:0]};
        end
    end

    // Sequencer state, datapath registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            a_r        <= 64'd0;
            n_r        <= 13'sd0;
            neg_n_fp_r <= 64'd0;
            f_r        <= 64'd0;
            acc_r      <= 64'd0;
            k_r        <= 3'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            y          <= 64'd0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
            inexact    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        a_r        <= a;
                        n_r        <= n_s;
                        neg_n_fp_r <= neg_n_fp_s;
                        busy       <= 1'b1;
                        state_r    <= (is_zero_s || is_inf_s || is_nan_s) ? ST_SPECIAL : ST_SPLIT;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_SPECIAL: begin
                    y         <= special_y_s;
                    overflow  <= 1'b0;
                    underflow <= 1'b0;
                    inexact   <= 1'b0;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    state_r   <= ST_IDLE;
                end
                ST_SPLIT: begin
                    f_r     <= add_y_s;
                    acc_r   <= exp2_coef(3'(ORDER));
                    k_r     <= 3'(ORDER - 1);
                    state_r <= ST_MUL;
                end
                ST_MUL: begin
                    acc_r   <= mul_y_s;
                    state_r <= ST_ADD;
                end
                ST_ADD: begin
                    acc_r <= add_y_s;
                    if (k_r == 3'd0) begin
                        state_r <= ST_SCALE;
                    end else begin
                        k_r     <= k_r - 3'd1;
                        state_r <= ST_MUL;
                    end
                end
                ST_SCALE: begin
                    y         <= scale_y_s;
                    overflow  <= scale_ov_s;
                    underflow <= scale_un_s;
                    inexact   <= 1'b1;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    state_r   <= ST_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp64_exp2_seq.sv
// Directed-vector bench for fp64_exp2_seq with hand-computed results.
module tb_fp64_exp2_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [63:0] a = 64'd0;
    logic        busy, done, overflow, underflow, inexact;
    logic [63:0] y;
    int          pass_cnt = 0;
    int          total_cnt = 0;

    always #5 clk = ~clk;

    fp64_exp2_seq #(.ORDER(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (a),
        .busy      (busy),
        .done      (done),
        .y         (y),
        .overflow  (overflow),
        .underflow (underflow),
        .inexact   (inexact)
    );

    task automatic issue(input logic [63:0] op);
        @(negedge clk);
        start = 1'b1;
        a     = op;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Edges from accept to done; -1 when no done within the bound.
    task automatic wait_done(output int edges);
        edges = 0;
        while (edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
            if (done === 1'b1) break;
        end
        if (done !== 1'b1) edges = -1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total_cnt++; if (y !== 64'd0) $display("FAIL reset_y got %h want 0", y); else pass_cnt++;
        total_cnt++; if ({busy, done} !== 2'b00) $display("FAIL reset_busy_done got %b want 00", {busy, done}); else pass_cnt++;
        total_cnt++; if ({overflow, underflow, inexact} !== 3'b000) $display("FAIL reset_flags got %b want 000", {overflow, underflow, inexact}); else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_one();
        int e;
        issue(64'h3FF0000000000000);
        total_cnt++; if (busy !== 1'b1) $display("FAIL one_busy got %b want 1", busy); else pass_cnt++;
        wait_done(e);
        total_cnt++; if (e !== 14) $display("FAIL one_latency got %0d want 14", e); else pass_cnt++;
        total_cnt++; if (y !== 64'h4000000000000000) $display("FAIL one_y got %h want 4000000000000000", y); else pass_cnt++;
        total_cnt++; if ({overflow, underflow, inexact} !== 3'b001) $display("FAIL one_flags got %b want 001", {overflow, underflow, inexact}); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL one_busy_end got %b want 0", busy); else pass_cnt++;
        @(posedge clk);
        #1;
        total_cnt++; if (done !== 1'b0) $display("FAIL one_done_pulse got %b want 0", done); else pass_cnt++;
        total_cnt++; if (y !== 64'h4000000000000000) $display("FAIL one_y_hold got %h want 4000000000000000", y); else pass_cnt++;
    endtask

    task automatic test_powers();
        logic [63:0] ops [2];
        logic [63:0] exp_y [2];
        int e;
        ops[0] = 64'hC000000000000000; exp_y[0] = 64'h3FD0000000000000;
        ops[1] = 64'h4008000000000000; exp_y[1] = 64'h4020000000000000;
        for (int i = 0; i < 2; i++) begin
            issue(ops[i]);
            wait_done(e);
            total_cnt++; if (e !== 14) $display("FAIL pow_latency[%0d] got %0d want 14", i, e); else pass_cnt++;
            total_cnt++; if (y !== exp_y[i]) $display("FAIL pow_y[%0d] got %h want %h", i, y, exp_y[i]); else pass_cnt++;
            total_cnt++; if ({overflow, underflow, inexact} !== 3'b001) $display("FAIL pow_flags[%0d] got %b want 001", i, {overflow, underflow, inexact}); else pass_cnt++;
        end
    endtask

    task automatic test_special();
        logic [63:0] ops [5];
        logic [63:0] exp_y [5];
        int e;
        ops[0] = 64'h0000000000000000; exp_y[0] = 64'h3FF0000000000000;
        ops[1] = 64'h8000000000000000; exp_y[1] = 64'h3FF0000000000000;
        ops[2] = 64'hFFF0000000000000; exp_y[2] = 64'h0000000000000000;
        ops[3] = 64'h7FF0000000000000; exp_y[3] = 64'h7FF0000000000000;
        ops[4] = 64'hFFF4000000000000; exp_y[4] = 64'h7FFC000000000000;
        for (int i = 0; i < 5; i++) begin
            issue(ops[i]);
            wait_done(e);
            total_cnt++; if (e !== 1) $display("FAIL spec_latency[%0d] got %0d want 1", i, e); else pass_cnt++;
            total_cnt++; if (y !== exp_y[i]) $display("FAIL spec_y[%0d] got %h want %h", i, y, exp_y[i]); else pass_cnt++;
            total_cnt++; if ({overflow, underflow, inexact} !== 3'b000) $display("FAIL spec_flags[%0d] got %b want 000", i, {overflow, underflow, inexact}); else pass_cnt++;
        end
    endtask

    task automatic test_range();
        logic [63:0] ops [2];
        logic [63:0] exp_y [2];
        logic [2:0]  exp_f [2];
        int e;
        ops[0] = 64'h4091300000000000; exp_y[0] = 64'h7FF0000000000000; exp_f[0] = 3'b101;
        ops[1] = 64'hC091300000000000; exp_y[1] = 64'h0000000000000000; exp_f[1] = 3'b011;
        for (int i = 0; i < 2; i++) begin
            issue(ops[i]);
            wait_done(e);
            total_cnt++; if (e !== 14) $display("FAIL range_latency[%0d] got %0d want 14", i, e); else pass_cnt++;
            total_cnt++; if (y !== exp_y[i]) $display("FAIL range_y[%0d] got %h want %h", i, y, exp_y[i]); else pass_cnt++;
            total_cnt++; if ({overflow, underflow, inexact} !== exp_f[i]) $display("FAIL range_flags[%0d] got %b want %b", i, {overflow, underflow, inexact}, exp_f[i]); else pass_cnt++;
        end
    endtask

    task automatic test_start_while_busy();
        int first_done = -1;
        int done_cnt = 0;
        logic [63:0] y_at_done = 64'd0;
        issue(64'h3FF0000000000000);
        for (int i = 1; i <= 30; i++) begin
            start = (i <= 12);
            a     = i[0] ? 64'h4008000000000000 : 64'hC000000000000000;
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                done_cnt++;
                if (first_done < 0) begin
                    first_done = i;
                    y_at_done  = y;
                end
            end
        end
        start = 1'b0;
        total_cnt++; if (done_cnt !== 1) $display("FAIL busy_done_count got %0d want 1", done_cnt); else pass_cnt++;
        total_cnt++; if (first_done !== 14) $display("FAIL busy_latency got %0d want 14", first_done); else pass_cnt++;
        total_cnt++; if (y_at_done !== 64'h4000000000000000) $display("FAIL busy_y got %h want 4000000000000000", y_at_done); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int e;
        issue(64'h4008000000000000);
        wait_done(e);
        total_cnt++; if (y !== 64'h4020000000000000) $display("FAIL b2b_first_y got %h want 4020000000000000", y); else pass_cnt++;
        start = 1'b1;
        a     = 64'hC000000000000000;
        @(posedge clk);
        #1;
        start = 1'b0;
        total_cnt++; if (busy !== 1'b1) $display("FAIL b2b_busy got %b want 1", busy); else pass_cnt++;
        wait_done(e);
        total_cnt++; if (e !== 14) $display("FAIL b2b_latency got %0d want 14", e); else pass_cnt++;
        total_cnt++; if (y !== 64'h3FD0000000000000) $display("FAIL b2b_second_y got %h want 3fd0000000000000", y); else pass_cnt++;
    endtask

    task automatic test_rst_mid();
        int e;
        int done_cnt = 0;
        issue(64'h3FF0000000000000);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        total_cnt++; if ({busy, done} !== 2'b00) $display("FAIL rst_mid_busy_done got %b want 00", {busy, done}); else pass_cnt++;
        total_cnt++; if (y !== 64'd0) $display("FAIL rst_mid_y got %h want 0", y); else pass_cnt++;
        total_cnt++; if ({overflow, underflow, inexact} !== 3'b000) $display("FAIL rst_mid_flags got %b want 000", {overflow, underflow, inexact}); else pass_cnt++;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) done_cnt++;
        end
        total_cnt++; if (done_cnt !== 0) $display("FAIL rst_mid_stray_done got %0d want 0", done_cnt); else pass_cnt++;
        issue(64'h3FF0000000000000);
        wait_done(e);
        total_cnt++; if (e !== 14) $display("FAIL rst_mid_next_latency got %0d want 14", e); else pass_cnt++;
        total_cnt++; if (y !== 64'h4000000000000000) $display("FAIL rst_mid_next_y got %h want 4000000000000000", y); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_one();
        test_powers();
        test_special();
        test_range();
        test_start_while_busy();
        test_back_to_back();
        test_rst_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/fp64_exp2_seq.md
Name: fp64_exp2_seq

Overview:
Multi-cycle sequencer that computes y = 2^a for an IEEE-754 binary64 operand using one shared fp64_mul and one shared fp64_add instance. It replaces the fully combinational parallel polynomial tree with a Horner-form evaluation driven by a state machine. It sits in the FPU beside the transcendental units (F2XM1/FSCALE paths) and exchanges operands and results through a start/done handshake with the FPU microsequencer.

Parameters:
ORDER, 6, polynomial degree; legal range 1..6; uses coefficients C0..C_ORDER; normal-path latency = 2*ORDER+2 edges.

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
start  input  1  request; accepted only when the FSM is in IDLE
a  input  64  binary64 operand; captured on the accepting edge
busy  output  1  high while an accepted operation is in flight
done  output  1  one-cycle pulse; y and flags are valid while done=1 and hold until the next done
y  output  64  binary64 result
overflow  output  1  result saturated to +inf
underflow  output  1  result flushed to +0
inexact  output  1  result rounded or approximated

Behaviour:
- Interface: one clock `clk`; `rst` is synchronous and active-high.
- Reset values: y=0, overflow=0, underflow=0, inexact=0, busy=0, done=0; FSM=IDLE; step counter=0.
- States: IDLE, SPECIAL, SPLIT, MUL, ADD, SCALE.
- IDLE, start=1: latch a.
  - a is zero, inf or NaN: go to SPECIAL.
  - Otherwise: compute n and go to SPLIT.
  - busy rises on the accepting edge.
- n is trunc-toward-zero of a, held as 13-bit signed.
  - n=0 if the exponent field is 0.
  - n=±1024 if the unbiased exponent is >=13.
- SPLIT: f_reg <= a + (-float(n)) via the shared adder. Then acc <= C_ORDER, k <= ORDER-1, go to MUL.
- MUL: acc <= acc*f_reg via the shared multiplier; go to ADD.
- ADD: acc <= acc + C_k via the shared adder.
  - k=0: go to SCALE.
  - Otherwise: k <= k-1 and go to MUL.
- SCALE: compute exp_adj = {2'b00, acc[62:52]} + n, as 13-bit signed. Register results as follows:
  - acc exponent==0: y=acc, no flags.
  - exp_adj>=2047: y=0x7FF0000000000000, overflow=1.
  - exp_adj<=0: y=0, underflow=1.
  - Otherwise: y={acc[63], exp_adj[10:0], acc[51:0]}.
  - Every SCALE result sets inexact=1.
  - On the same edge: done=1, busy=0, FSM=IDLE.
- SPECIAL: register y and flags on the next edge; done=1, busy=0, FSM=IDLE. In all cases overflow=underflow=inexact=0.
  - ±0 gives y=0x3FF0000000000000.
  - +inf gives y=0x7FF0000000000000.
  - -inf gives y=0.
  - NaN gives y={0, 7FF, 1, a[50:0]} (quieted, sign cleared).
- Latency, counted in edges after the accepting edge:
  - Normal path: done at edge 2*ORDER+2 (14 for ORDER=6).
  - Special path: done at edge 1.
- done is forced low on every edge it is not explicitly set.
- start while busy=1 is ignored; no queuing.
- start in the done cycle is accepted, giving back-to-back operation; the FSM is already in IDLE.
- rst mid-operation: FSM returns to IDLE on that edge, all outputs go to reset values, and no done is produced for the discarded operation.
- Shared-unit multiplexing: operand muxes are selected by FSM state only. Adder inputs are {a, -n_fp} in SPLIT and {acc, C_k} in ADD. No combinational path from start or a to any output.

Decomposition:
- Shared package/include (alongside defines.v) holds:
  - coefficients C0..C6 (C0=0x3FF0000000000000, C1=0x3FE62E42FEFA39EF, C2=0x3FCEBFBDFF82C58E, C3=0x3FAC6B08D704A0BF, C4=0x3F83B2AB6FBA4E77, C5=0x3F55D87FE78A6730, C6=0x3F2430912F86C786);
  - FP64_POS_INF, FP64_ONE and EXP_BIAS=1023;
  - FSM state encoding.
- One sub-module: fp64_exp2_prep (combinational). It performs operand classification (zero/inf/NaN), trunc-to-int n with saturation, and int-to-fp64 conversion of n.
- The FSM, muxes, and single fp64_mul / fp64_add instances live in the top module.

Test Plan:
1. a=0x3FF0000000000000 (1.0), start pulse: busy=1 next cycle; done exactly 14 edges after accept; y=0x4000000000000000; inexact=1, overflow=underflow=0.
2. a=0xC000000000000000 (-2.0): y=0x3FD0000000000000. Then a=0x4008000000000000 (3.0): y=0x4020000000000000.
3. Specials, done 1 edge after accept, all flags 0:
   - a=0 gives y=0x3FF0000000000000.
   - a=0xFFF0000000000000 gives y=0.
   - a=0x7FF0000000000000 gives y=0x7FF0000000000000.
   - a=0xFFF4000000000000 gives y=0x7FFC000000000000.
4. Range limits:
   - a=0x4091300000000000 (1100.0): y=0x7FF0000000000000, overflow=1.
   - a=0xC091300000000000 (-1100.0): y=0, underflow=1.
5. Handshake:
   - start held high during busy with a changing: result matches the originally captured operand, no extra done.
   - start asserted in the done cycle: second result's done 14 edges later.
6. rst=1 for one cycle at edge 6 of an operation: busy=0, y=0, flags=0 next cycle; no done ever appears for that operation; a following 1.0 request completes normally.
